// File: rtl/sys_timer_pkg.sv
// Shared types for the system timer block: register width and counter selection.
package RV32Consts;
  typedef logic [31:0] IntReg;
endpackage

package SysTimerConsts;
  typedef enum logic [1:0] {
    CYCLE   = 2'd0,
    TIME    = 2'd1,
    INSTRET = 2'd2
  } Type;

  localparam int unsigned TIME_DIV_DEFAULT = 100;
endpackage

// File: rtl/sys_timer_if.sv
// Read port between the CSR unit (requester) and the system timer (responder).
interface SysTimerIF;
  import SysTimerConsts::*;

  Type               timer;
  logic              upper;
  RV32Consts::IntReg data;

  modport CSRUnitPort  (output timer, output upper, input  data);
  modport SysTimerPort (input  timer, input  upper, output data);
endinterface

// File: rtl/sys_timer_counter64.sv
// Free-running 64-bit counter with synchronous clear; wraps silently at 2^64-1.
module sys_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [63:0] count
);
  logic [63:0] cnt_q;

  // Single 64-bit add keeps the bit-31 carry inside one clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign count = cnt_q;
endmodule

// File: rtl/sys_timer.sv
// CYCLE / TIME / INSTRET counters with a TIME prescaler and a zero-latency read mux.
module sys_timer
  import SysTimerConsts::*;
#(
  parameter int unsigned TIME_DIV = TIME_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   count_en,
  input  logic                   retire,
  SysTimerIF.SysTimerPort        sys_timer_if
);
  logic [15:0] prescaler;
  logic        time_tick;
  logic [63:0] cycle_cnt;
  logic [63:0] time_cnt;
  logic [63:0] instret_cnt;
  logic [63:0] sel_cnt;

  assign time_tick = (prescaler == 16'(TIME_DIV - 1));

  // TIME runs off the raw clock; count_en deliberately does not gate it.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
    end else if (time_tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  sys_counter64 u_cycle (
    .clk   (clk),
    .reset (reset),
    .inc   (count_en),
    .count (cycle_cnt)
  );

  sys_counter64 u_time (
    .clk   (clk),
    .reset (reset),
    .inc   (time_tick),
    .count (time_cnt)
  );

  sys_counter64 u_instret (
    .clk   (clk),
    .reset (reset),
    .inc   (count_en & retire),
    .count (instret_cnt)
  );

  always_comb begin
    sel_cnt = '0;
    case (sys_timer_if.timer)
      CYCLE:   sel_cnt = cycle_cnt;
      TIME:    sel_cnt = time_cnt;
      INSTRET: sel_cnt = instret_cnt;
      default: sel_cnt = '0;
    endcase
    sys_timer_if.data = sys_timer_if.upper ? sel_cnt[63:32] : sel_cnt[31:0];
  end
endmodule

// File: tb/tb_sys_timer.sv
// Scoreboard bench for sys_timer: clock-count reference model, queued expectations, negedge monitor.
module tb_sys_timer;
  import SysTimerConsts::*;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic reset, count_en, retire;

  SysTimerIF if0 ();
  SysTimerIF if1 ();

  sys_timer #(.TIME_DIV(DIV)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .count_en     (count_en),
    .retire       (retire),
    .sys_timer_if (if0)
  );

  sys_timer #(.TIME_DIV(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .count_en     (count_en),
    .retire       (retire),
    .sys_timer_if (if1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned kind;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference state: plain counts since the last reset edge.
  longint unsigned cyc, cyc1, ins, clocks;

  function automatic logic [31:0] pick(input Type t, input logic up,
                                       input logic [63:0] c, input logic [63:0] tm,
                                       input logic [63:0] i);
    logic [63:0] v;
    case (t)
      CYCLE:   v = c;
      TIME:    v = tm;
      INSTRET: v = i;
      default: v = 64'd0;
    endcase
    return up ? v[63:32] : v[31:0];
  endfunction

  item_t       mit;
  logic [31:0] mact;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mit = q.pop_front();
      case (mit.kind)
        0:       mact = if0.data;
        1:       mact = if1.data;
        default: mact = 32'(dut0.prescaler);
      endcase
      checks++;
      if (mact !== mit.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", mit.name, mact, mit.exp);
      end
    end
  end

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rs, input logic ce, input logic rt,
                      input Type t, input logic up, input string name, input logic chk_pre);
    reset    = rs;
    count_en = ce;
    retire   = rt;
    if0.timer = t;  if0.upper = up;
    if1.timer = t;  if1.upper = up;
    q.push_back('{name, 0, pick(t, up, cyc, clocks / DIV, ins)});
    q.push_back('{{name, "_div1"}, 1, pick(t, up, cyc1, clocks, ins)});
    if (chk_pre) q.push_back('{{name, "_prescaler"}, 2, 32'(clocks % DIV)});
    @(posedge clk);
    if (rs) begin
      cyc = 0; cyc1 = 0; ins = 0; clocks = 0;
    end else begin
      clocks++;
      if (ce) begin
        cyc++;
        cyc1++;
        if (rt) ins++;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; count_en = 1'b0; retire = 1'b0;
    if0.timer = CYCLE; if0.upper = 1'b0;
    if1.timer = CYCLE; if1.upper = 1'b0;
    @(posedge clk); #1;
    cyc = 0; cyc1 = 0; ins = 0; clocks = 0;

    // Reset held with enables active: every selection reads zero.
    for (int t = 0; t < 3; t++)
      for (int u = 0; u < 2; u++)
        step(1'b1, 1'b1, 1'b1, Type'(2'(t)), 1'(u), "reset_zero", 1'b1);

    check_now("reset_state_data0", if0.data, 32'd0);
    check_now("reset_state_data1", if1.data, 32'd0);
    check_now("reset_state_prescaler", 32'(dut0.prescaler), 32'd0);

    repeat (10) step(1'b0, 1'b1, 1'b0, CYCLE, 1'b0, "cycle_run", 1'b0);
    step(1'b0, 1'b0, 1'b0, CYCLE, 1'b0, "cycle10_lo", 1'b0);
    step(1'b0, 1'b0, 1'b0, CYCLE, 1'b1, "cycle10_hi", 1'b0);

    step(1'b1, 1'b0, 1'b0, TIME, 1'b0, "rst_a", 1'b0);
    repeat (17) step(1'b0, 1'b0, 1'b0, TIME, 1'b0, "time_run", 1'b1);
    step(1'b0, 1'b0, 1'b0, TIME, 1'b0, "time17", 1'b1);

    step(1'b1, 1'b0, 1'b0, INSTRET, 1'b0, "rst_b", 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b1, INSTRET, 1'b0, "retire_en", 1'b0);
      step(1'b0, 1'b1, 1'b0, CYCLE, 1'b0, "retire_gap", 1'b0);
    end
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b1, CYCLE, 1'b0, "cycle_frozen", 1'b0);
    step(1'b0, 1'b0, 1'b0, INSTRET, 1'b0, "instret5", 1'b0);

    // Includes the unlisted selector encoding and occasional resets.
    repeat (300)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           Type'(2'($urandom_range(0, 3))), 1'($urandom_range(0, 1)), "random",
           1'($urandom_range(0, 3) == 0));

    force dut0.u_cycle.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut0.u_cycle.cnt_q;
    cyc = 64'h0000_0000_FFFF_FFFF;
    step(1'b0, 1'b1, 1'b0, CYCLE, 1'b0, "carry_pre", 1'b0);
    step(1'b0, 1'b0, 1'b0, CYCLE, 1'b0, "carry_lo", 1'b0);
    step(1'b0, 1'b0, 1'b0, CYCLE, 1'b1, "carry_hi", 1'b0);

    force dut0.u_cycle.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut0.u_cycle.cnt_q;
    cyc = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1'b0, 1'b1, 1'b0, CYCLE, 1'b1, "wrap_pre", 1'b0);
    step(1'b0, 1'b0, 1'b0, CYCLE, 1'b0, "wrap_lo", 1'b0);
    step(1'b0, 1'b0, 1'b0, CYCLE, 1'b1, "wrap_hi", 1'b0);

    for (int k = 0; k < 8 && (clocks % DIV) != DIV - 2; k++)
      step(1'b0, 1'b1, 1'b1, TIME, 1'b0, "align_mid", 1'b1);
    step(1'b1, 1'b1, 1'b1, TIME, 1'b0, "mid_reset", 1'b1);
    for (int t = 0; t < 3; t++)
      for (int u = 0; u < 2; u++)
        step(1'b1, 1'b1, 1'b1, Type'(2'(t)), 1'(u), "post_reset_zero", 1'b1);
    for (int k = 0; k <= int'(DIV) + 1; k++)
      step(1'b0, 1'b1, 1'b0, TIME, 1'b0, "first_tick", 1'b1);

    check_now("expired_wait_time", if0.data, 32'(clocks / DIV));
    check_now("expired_wait_prescaler", 32'(dut0.prescaler), 32'(clocks % DIV));

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
